// File: rtl/id_control_pipeline.sv
// ID-stage control unit: decodes IF/ID, registers ID/EX control, detects load-use hazards.
// Optional macro ILLEGAL_INSN_EN flags illegal encodings on ex_illegal (tied to 0 otherwise).
module id_control_pipeline #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic [3:0]      ex_funct,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign f3     = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign f7     = id_instr[31:25];

    logic is_r, is_i, is_lw, is_sw, is_beq;
    logic legal, rs1_used, rs2_used;

    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_beq = 1'b0;
        case (opcode)
            7'b0110011: is_r = ((f7 == 7'b0000000) &&
                                (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b101)) ||
                               ((f7 == 7'b0100000) && (f3 == 3'b000));
            7'b0010011: is_i   = (f3 == 3'b000) || (f3 == 3'b110);
            7'b0000011: is_lw  = (f3 == 3'b010);
            7'b0100011: is_sw  = (f3 == 3'b010);
            7'b1100011: is_beq = (f3 == 3'b000);
            default: ;
        endcase
    end

    assign legal    = is_r | is_i | is_lw | is_sw | is_beq;
    assign rs1_used = legal;
    assign rs2_used = is_r | is_sw | is_beq;

    logic hazard;
    assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((rs1_used & (ex_rd == rs1)) | (rs2_used & (ex_rd == rs2)));
    // A flushed instruction is discarded anyway, so it never needs to wait.
    assign stall = hazard & ~flush;

    logic load_bubble;
    logic illegal_flag;
    assign load_bubble = ~id_valid | ~legal | flush | stall;

`ifdef ILLEGAL_INSN_EN
    assign illegal_flag = id_valid & ~legal & ~flush & ~stall;
`else
    assign illegal_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || load_bubble) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_funct      <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_illegal    <= rst_n & illegal_flag;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= is_r ? 2'b10 : is_i ? 2'b11 : is_beq ? 2'b01 : 2'b00;
            ex_funct      <= {is_i ? 1'b0 : id_instr[30], f3};
            ex_alu_src    <= is_i | is_lw | is_sw;
            ex_mem_read   <= is_lw;
            ex_mem_write  <= is_sw;
            ex_reg_write  <= is_r | is_i | is_lw;
            ex_mem_to_reg <= is_lw;
            ex_branch     <= is_beq;
            ex_rs1        <= rs1;
            ex_rs2        <= rs2;
            ex_rd         <= (is_sw | is_beq) ? 5'd0 : rd;
            ex_illegal    <= 1'b0;
        end
    end

endmodule
